ps2_scancode_ctrl: RTL
======================

PS2_SCANCODE_CTRL -- requirements
Module: ps2_scancode_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, event FIFO depth; power of 2, minimum 2.
REQ-002 Parameter: T_TIMEOUT, 17'd100000, prefix-state timeout in CLOCK cycles (2 ms at 50 MHz).
REQ-003 CLOCK  in  1  system clock; all state changes on the rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 iTrig  in  1  one-cycle strobe from the PS/2 byte receiver; iData is valid in that cycle.
REQ-006 iData  in  8  received scancode byte.
REQ-007 iRead  in  1  consumer pop strobe for the event FIFO.
REQ-008 oEmpty  out  1  high when the event FIFO holds no events.
REQ-009 oData  out  10  FIFO head {ext, brk, code[7:0]}; show-ahead, valid while oEmpty=0.
REQ-010 oMod  out  4  live modifier state {caps, alt, ctrl, shift}.
REQ-011 oPause  out  1  one-cycle pulse when a complete Pause sequence is decoded.
REQ-012 oOverflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-013 The FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen) and PAUSE (E1 seen). It SHALL advance only on cycles with iTrig=1.
REQ-014 From IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter=7; AA, FA, EE, FE, 00 or FF -> discarded, stay in IDLE; any other byte -> emit {0,0,byte}, stay in IDLE.
REQ-015 From EXT: F0 -> EXTBRK; E0 -> stay in EXT; other byte -> emit {1,0,byte} and go to IDLE.
REQ-016 From BRK: emit {0,1,byte} and go to IDLE. From EXTBRK: emit {1,1,byte} and go to IDLE.
REQ-017 PAUSE: each byte decrements the skip counter. When the counter reaches 0 (8th byte of the E1 sequence), oPause SHALL pulse for 1 cycle and the FSM returns to IDLE. No FIFO event is written.
REQ-018 Timeout: in any non-IDLE state, a counter runs on every cycle without iTrig. When it reaches T_TIMEOUT-1, the FSM returns to IDLE with no event. The counter clears on every iTrig and on entry to IDLE.
REQ-019 Latency: for the final byte of a sequence, with iTrig at cycle N, the event SHALL be in the FIFO and oEmpty=0 at cycle N+1 (registered write).
REQ-020 Modifier updates SHALL occur in the same cycle as the event write, whether or not the FIFO accepts the event:
  - shift = held(12) OR held(59)
  - ctrl = held(14) OR held(E0 14)
  - alt = held(11) OR held(E0 11)
  - "held" is set on make and cleared on break.
REQ-021 caps SHALL toggle only on a non-extended make of 58 while 58 is not already held. Typematic repeats SHALL NOT toggle it. A break of 58 clears the held bit.
REQ-022 FIFO: write when an event is emitted; pop on iRead=1 with oEmpty=0. iRead while empty is ignored with no pointer change.
REQ-023 Write while full with no pop: the event is dropped and oOverflow is set to 1. oOverflow stays 1 until reset.
REQ-024 Write and pop in the same cycle while full: both are performed; no overflow; occupancy stays at FIFO_DEPTH.
REQ-025 Write and pop in the same cycle while empty is impossible (no pop when empty): the write proceeds and oEmpty=0 next cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH. The occupancy count width SHALL be log2(FIFO_DEPTH)+1.

Reset
REQ-027 While RESET=1: FSM=IDLE; skip and timeout counters=0; FIFO pointers and count=0; oEmpty=1; oData=10'd0; oMod=4'b0000; all held bits=0; oPause=0; oOverflow=0.
REQ-028 Reset asserted in the middle of a sequence SHALL discard the partial sequence. After release, the first byte SHALL be decoded from IDLE.

Verification
REQ-029 Bytes 1C, then F0 1C -> FIFO holds 01C then 11C; each is visible 1 cycle after its final iTrig; two iRead pops -> oEmpty=1.
REQ-030 Bytes E0 75, then E0 F0 75 -> events 275 and 375; E0 11 -> oMod[2]=1; E0 F0 11 -> oMod[2]=0.
REQ-031 Bytes 58, 58, 58 (typematic), F0 58, 58 -> caps=1 after the first make, unchanged by the repeats, caps=0 after the second make.
REQ-032 E1 14 77 E1 F0 14 F0 77 -> one oPause pulse on the cycle after the 8th byte; no FIFO event; modifiers unchanged.
REQ-033 Five make codes with no iRead (FIFO_DEPTH=4) -> 4 events retained, the 5th dropped, oOverflow=1. A 6th write with a simultaneous iRead is accepted and oOverflow stays 1.
REQ-034 E0 followed by an idle gap of T_TIMEOUT cycles, then 1C -> event 01C with no ext bit. A RESET pulse after F0, then 1C -> event 01C with no brk bit.

Source files
------------

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scancode decoder: turns raw set-2 bytes into {ext, brk, code} key events
// buffered in a small show-ahead FIFO, and tracks live modifier state plus Pause.
module ps2_scancode_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [16:0] T_TIMEOUT  = 17'd100000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iTrig,
  input  logic [7:0] iData,
  input  logic       iRead,
  output logic       oEmpty,
  output logic [9:0] oData,
  output logic [3:0] oMod,
  output logic       oPause,
  output logic       oOverflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

  state_t      state, stateNext;
  logic [2:0]  skipCnt, skipNext;
  logic [16:0] toCnt;
  logic        pauseHit;
  logic        evVld_p0;
  logic [9:0]  evData_p0;

  logic [9:0]    evMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          doPop, doWrite, full;

  logic lShift, rShift, lCtrl, rCtrl, lAlt, rAlt, capsHeld, caps;

  // Stage 0: byte decode (combinational, acts on the iTrig cycle)
  always_comb begin
    stateNext = state;
    skipNext  = skipCnt;
    pauseHit  = 1'b0;
    evVld_p0  = 1'b0;
    evData_p0 = 10'd0;
    if (iTrig) begin
      unique case (state)
        IDLE: begin
          unique case (iData)
            8'hE0: stateNext = EXT;
            8'hF0: stateNext = BRK;
            8'hE1: begin
              stateNext = PAUSE;
              skipNext  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
              evVld_p0  = 1'b1;
              evData_p0 = {2'b00, iData};
            end
          endcase
        end
        EXT: begin
          if (iData == 8'hF0) begin
            stateNext = EXTBRK;
          end else if (iData != 8'hE0) begin
            evVld_p0  = 1'b1;
            evData_p0 = {2'b10, iData};
            stateNext = IDLE;
          end
        end
        BRK: begin
          evVld_p0  = 1'b1;
          evData_p0 = {2'b01, iData};
          stateNext = IDLE;
        end
        EXTBRK: begin
          evVld_p0  = 1'b1;
          evData_p0 = {2'b11, iData};
          stateNext = IDLE;
        end
        PAUSE: begin
          // E1 itself loaded 7; the 8th byte of the sequence arrives with 1 left
          skipNext = skipCnt - 3'd1;
          if (skipCnt == 3'd1) begin
            pauseHit  = 1'b1;
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else if (state != IDLE && toCnt == T_TIMEOUT - 17'd1) begin
      stateNext = IDLE;
      skipNext  = 3'd0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      skipCnt <= 3'd0;
      toCnt   <= 17'd0;
      oPause  <= 1'b0;
    end else begin
      state   <= stateNext;
      skipCnt <= skipNext;
      oPause  <= pauseHit;
      toCnt   <= (iTrig || stateNext == IDLE) ? 17'd0 : toCnt + 17'd1;
    end
  end

  // Stage 1: modifier tracking, updated with every emitted event even if dropped
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      lShift   <= 1'b0;
      rShift   <= 1'b0;
      lCtrl    <= 1'b0;
      rCtrl    <= 1'b0;
      lAlt     <= 1'b0;
      rAlt     <= 1'b0;
      capsHeld <= 1'b0;
      caps     <= 1'b0;
    end else if (evVld_p0) begin
      unique case (evData_p0[7:0])
        8'h12: if (!evData_p0[9]) lShift <= !evData_p0[8];
        8'h59: if (!evData_p0[9]) rShift <= !evData_p0[8];
        8'h14: if (evData_p0[9]) rCtrl <= !evData_p0[8]; else lCtrl <= !evData_p0[8];
        8'h11: if (evData_p0[9]) rAlt <= !evData_p0[8]; else lAlt <= !evData_p0[8];
        8'h58: begin
          if (!evData_p0[9]) begin
            if (evData_p0[8]) begin
              capsHeld <= 1'b0;
            end else begin
              if (!capsHeld) caps <= ~caps;
              capsHeld <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign oMod = {caps, lAlt | rAlt, lCtrl | rCtrl, lShift | rShift};

  // Stage 1: event FIFO; a pop in the same cycle frees the slot for a full-FIFO write
  assign full    = (count == DEPTH_C);
  assign oEmpty  = (count == '0);
  assign doPop   = iRead && !oEmpty;
  assign doWrite = evVld_p0 && (!full || doPop);
  assign oData   = oEmpty ? 10'd0 : evMem[rdPtr];

  always_ff @(posedge CLOCK) begin
    if (doWrite) evMem[wrPtr] <= evData_p0;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)   rdPtr <= rdPtr + PTR_ONE;
      unique case ({doWrite, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (evVld_p0 && full && !doPop) oOverflow <= 1'b1;
    end
  end

endmodule
